control_sequencer: RTL and testbench
====================================

# control_sequencer

Microcoded control unit for the 8-bit bus computer: replaces the hand-driven DIP control lines with an instruction register, a 5-step micro-step counter, a flags register and a microcode decode. It sits on the shared 8-bit `bus` next to the ALU, RAM, program counter and seven-segment output, and drives their control inputs. Execution is free-running or single-stepped from a button, and stops on HLT.

## Interface
Parameters:
- none (the instruction set and step count are fixed constants in `control_defs`)

Ports:
- `clk`  in  1  system clock (the slow datapath clock); the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `bus`  inout  8  shared main bus; driven only while IO is asserted, otherwise high-Z.
- `run`  in  1  level; 1 = advance every cycle.
- `step`  in  1  one-cycle pulse; advances exactly one micro-step when `run`=0.
- `carry_in`, `zero_in`  in  1 each  ALU carry and zero results.
- `load_A`, `load_B`, `write_A`, `write_B`, `write_ALU`, `subtract`  out  1 each  ALU/register controls.
- `MI`, `RO`, `RI`  out  1 each  RAM controls.
- `CO`, `CE`, `J`  out  1 each  program-counter controls.
- `OI`  out  1  output-register load.
- `halted`  out  1  registered; 1 after HLT executes.
- `step_idx`  out  3  current micro-step (0–4), for debug LEDs.

## Operation
- State: IR[7:0], step[2:0], C and Z flag bits, halted.
- opcode = IR[7:4]; operand = IR[3:0]. IO drives `bus` = {4'h0, IR[3:0]}.
- Advance enable `adv` = (`run` | `step`) & ~`halted`.
  - When `adv`=0, every control output is 0, IO is 0 and state holds.
  - When `adv`=1, outputs = microcode(opcode, step, C, Z), and step increments at the clock edge, wrapping 4→0.
- Internal controls: II (IR ← bus), FI (C ← `carry_in`, Z ← `zero_in`), IO, HLT.
- Microcode:
  - Fetch, all opcodes: T0 = CO MI; T1 = RO II CE.
  - T2–T4 by opcode:
    - 0 NOP: –
    - 1 LDA: IO MI | RO load_A
    - 2 ADD: IO MI | RO load_B | write_ALU load_A FI
    - 3 SUB: as ADD, plus `subtract` in T4
    - 4 STA: IO MI | write_A RI
    - 5 LDI: IO load_A
    - 6 JMP: IO J
    - 7 JC: IO J only if C=1
    - 8 JZ: IO J only if Z=1
    - E OUT: write_A OI
    - F HLT: HLT in T2
    - 9–D: NOP
  - Unlisted steps are empty.
- HLT: `halted` is set at the edge that ends T2 and step freezes at 3. `halted` clears only on `rst`.
- Conditional jumps use the flags registered before T2; FI within the same instruction cannot affect them.
- `run` and `step` both high: behaves as `run`.
- Reset: IR=0, step=0, C=Z=0, halted=0. All outputs 0 during the reset cycle. A reset mid-instruction abandons it; the next instruction fetches from whatever the PC reset to.

## Timing
- Control outputs are combinational from registered state gated by `adv`, valid for the whole cycle. The datapath samples them at the next rising `clk`.
- One instruction = 5 advancing cycles. IR is loaded at the edge ending T1. Flags update at the edge ending the FI cycle.
- `bus` is released the same cycle IO deasserts; no other bus driver is ever enabled alongside IO by the microcode.
- `step` pulse wider than one cycle advances once per high cycle; debouncing and edge detection are upstream.

## Structure
- Shared package/header `control_defs`:
  - opcode constants;
  - control-word bit indices;
  - NUM_STEPS=5;
  - FETCH step encodings.
- Sub-module `microcode_rom`: purely combinational (opcode, step, C, Z) → 17-bit control word (13 external + II, FI, IO, HLT).
- Top holds the registers, `adv` gating and the bus tri-state.

## Test plan
- Reset then `run`=1 with IR loaded from bus 0x1E: T0 CO+MI, T1 RO+II+CE, T2 IO+MI with bus=0x0E, T3 RO+load_A, T4 empty; step_idx 0,1,2,3,4,0.
- ADD with `carry_in`=1, `zero_in`=0 at T4: `write_ALU`+`load_A`+FI in T4, C=1 and Z=0 afterwards; SUB (0x3F) additionally asserts `subtract` only in T4.
- JC 0x75 with C=0: no J and no IO in T2. With C=1: IO+J in T2, bus=0x05. JZ 0x83 with Z=1: J in T2.
- HLT 0xF0: `halted`=1 after T2, all controls 0 thereafter regardless of `run`/`step`, step_idx=3. `rst` clears `halted` and step to 0.
- `run`=0 with three single-cycle `step` pulses separated by idle cycles: exactly three micro-steps execute; outputs are 0 on idle cycles; IR and flags are unchanged.
- Assert `rst` during T3 of ADD: next cycle step=0, IR=0, outputs 0, bus high-Z, C=Z=0.

Source files
------------

// File: rtl/control_defs.sv
// Shared definitions for the microcoded control sequencer: opcodes, micro-step
// encodings and control-word bit positions.
package control_defs;

  localparam int NUM_STEPS = 5;
  localparam int CW_W      = 17;

  typedef logic [3:0] opcode_t;
  typedef logic [2:0] mstep_t;

  localparam opcode_t OP_NOP = 4'h0;
  localparam opcode_t OP_LDA = 4'h1;
  localparam opcode_t OP_ADD = 4'h2;
  localparam opcode_t OP_SUB = 4'h3;
  localparam opcode_t OP_STA = 4'h4;
  localparam opcode_t OP_LDI = 4'h5;
  localparam opcode_t OP_JMP = 4'h6;
  localparam opcode_t OP_JC  = 4'h7;
  localparam opcode_t OP_JZ  = 4'h8;
  localparam opcode_t OP_OUT = 4'hE;
  localparam opcode_t OP_HLT = 4'hF;

  // T0/T1 are the shared fetch steps; T2-T4 execute the opcode.
  localparam mstep_t STEP_T0 = 3'd0;
  localparam mstep_t STEP_T1 = 3'd1;
  localparam mstep_t STEP_T2 = 3'd2;
  localparam mstep_t STEP_T3 = 3'd3;
  localparam mstep_t STEP_T4 = 3'd4;

  localparam int CW_LOAD_A    = 0;
  localparam int CW_LOAD_B    = 1;
  localparam int CW_WRITE_A   = 2;
  localparam int CW_WRITE_B   = 3;
  localparam int CW_WRITE_ALU = 4;
  localparam int CW_SUBTRACT  = 5;
  localparam int CW_MI        = 6;
  localparam int CW_RO        = 7;
  localparam int CW_RI        = 8;
  localparam int CW_CO        = 9;
  localparam int CW_CE        = 10;
  localparam int CW_J         = 11;
  localparam int CW_OI        = 12;
  localparam int CW_II        = 13;
  localparam int CW_FI        = 14;
  localparam int CW_IO        = 15;
  localparam int CW_HLT       = 16;

  function automatic mstep_t next_step(input mstep_t s);
    return (s == mstep_t'(NUM_STEPS - 1)) ? STEP_T0 : s + 3'd1;
  endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode decode: (opcode, micro-step, C, Z) -> control word.
module microcode_rom
  import control_defs::*;
(
  input  logic [3:0]      i_opcode,
  input  logic [2:0]      i_step,
  input  logic            i_c,
  input  logic            i_z,
  output logic [CW_W-1:0] o_cw
);

  logic [CW_W-1:0] w_cw;

  always_comb begin
    w_cw = '0;
    case (i_step)
      STEP_T0: begin
        w_cw[CW_CO] = 1'b1;
        w_cw[CW_MI] = 1'b1;
      end
      STEP_T1: begin
        w_cw[CW_RO] = 1'b1;
        w_cw[CW_II] = 1'b1;
        w_cw[CW_CE] = 1'b1;
      end
      default: begin
        case (i_opcode)
          OP_NOP: ;
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            if (i_step == STEP_T2) begin
              w_cw[CW_IO] = 1'b1;
              w_cw[CW_MI] = 1'b1;
            end else if (i_step == STEP_T3) begin
              if (i_opcode == OP_STA) begin
                w_cw[CW_WRITE_A] = 1'b1;
                w_cw[CW_RI]      = 1'b1;
              end else begin
                w_cw[CW_RO] = 1'b1;
                w_cw[CW_LOAD_A] = (i_opcode == OP_LDA);
                w_cw[CW_LOAD_B] = (i_opcode != OP_LDA);
              end
            end else if (i_step == STEP_T4 && i_opcode != OP_LDA && i_opcode != OP_STA) begin
              w_cw[CW_WRITE_ALU] = 1'b1;
              w_cw[CW_LOAD_A]    = 1'b1;
              w_cw[CW_FI]        = 1'b1;
              w_cw[CW_SUBTRACT]  = (i_opcode == OP_SUB);
            end
          end
          OP_LDI: begin
            if (i_step == STEP_T2) begin
              w_cw[CW_IO]     = 1'b1;
              w_cw[CW_LOAD_A] = 1'b1;
            end
          end
          OP_JMP, OP_JC, OP_JZ: begin
            // Conditional jumps see only flags latched by earlier instructions.
            if (i_step == STEP_T2 &&
                (i_opcode == OP_JMP || (i_opcode == OP_JC && i_c) || (i_opcode == OP_JZ && i_z))) begin
              w_cw[CW_IO] = 1'b1;
              w_cw[CW_J]  = 1'b1;
            end
          end
          OP_OUT: begin
            if (i_step == STEP_T2) begin
              w_cw[CW_WRITE_A] = 1'b1;
              w_cw[CW_OI]      = 1'b1;
            end
          end
          OP_HLT: begin
            if (i_step == STEP_T2) w_cw[CW_HLT] = 1'b1;
          end
          default: ;
        endcase
      end
    endcase
  end

  assign o_cw = w_cw;

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit: instruction register, micro-step counter, flags,
// halt latch, advance gating and the operand tri-state onto the shared bus.
module control_sequencer
  import control_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] bus,
  input  logic       run,
  input  logic       step,
  input  logic       carry_in,
  input  logic       zero_in,
  output logic       load_A,
  output logic       load_B,
  output logic       write_A,
  output logic       write_B,
  output logic       write_ALU,
  output logic       subtract,
  output logic       MI,
  output logic       RO,
  output logic       RI,
  output logic       CO,
  output logic       CE,
  output logic       J,
  output logic       OI,
  output logic       halted,
  output logic [2:0] step_idx
);

  logic [7:0]      r_ir;
  mstep_t          r_step;
  logic            r_c;
  logic            r_z;
  logic            r_halted;
  logic            w_adv;
  logic [CW_W-1:0] w_cw_rom;
  logic [CW_W-1:0] w_cw;

  microcode_rom u_rom (
    .i_opcode (r_ir[7:4]),
    .i_step   (r_step),
    .i_c      (r_c),
    .i_z      (r_z),
    .o_cw     (w_cw_rom)
  );

  // Reset also blanks the controls so nothing fires during the reset cycle.
  assign w_adv = (run | step) & ~r_halted & ~rst;
  assign w_cw  = w_adv ? w_cw_rom : '0;

  assign bus = w_cw[CW_IO] ? {4'h0, r_ir[3:0]} : 8'hzz;

  assign load_A    = w_cw[CW_LOAD_A];
  assign load_B    = w_cw[CW_LOAD_B];
  assign write_A   = w_cw[CW_WRITE_A];
  assign write_B   = w_cw[CW_WRITE_B];
  assign write_ALU = w_cw[CW_WRITE_ALU];
  assign subtract  = w_cw[CW_SUBTRACT];
  assign MI        = w_cw[CW_MI];
  assign RO        = w_cw[CW_RO];
  assign RI        = w_cw[CW_RI];
  assign CO        = w_cw[CW_CO];
  assign CE        = w_cw[CW_CE];
  assign J         = w_cw[CW_J];
  assign OI        = w_cw[CW_OI];
  assign halted    = r_halted;
  assign step_idx  = r_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir     <= 8'h00;
      r_step   <= STEP_T0;
      r_c      <= 1'b0;
      r_z      <= 1'b0;
      r_halted <= 1'b0;
    end else if (w_adv) begin
      // HLT in T2 still advances to T3, then halted blocks further advance.
      r_step <= next_step(r_step);
      if (w_cw[CW_II]) r_ir <= bus;
      if (w_cw[CW_FI]) begin
        r_c <= carry_in;
        r_z <= zero_in;
      end
      if (w_cw[CW_HLT]) r_halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer with a one-word RAM model on the bus.
module tb_control_sequencer;

  localparam logic [12:0] M_LA   = 13'h0001;
  localparam logic [12:0] M_LB   = 13'h0002;
  localparam logic [12:0] M_WALU = 13'h0010;
  localparam logic [12:0] M_SUB  = 13'h0020;
  localparam logic [12:0] M_MI   = 13'h0040;
  localparam logic [12:0] M_RO   = 13'h0080;
  localparam logic [12:0] M_CO   = 13'h0200;
  localparam logic [12:0] M_CE   = 13'h0400;
  localparam logic [12:0] M_J    = 13'h0800;

  logic clk = 1'b0;
  logic rst, run, step, carry_in, zero_in;
  logic [7:0] mem;
  wire  [7:0] bus;
  logic load_A, load_B, write_A, write_B, write_ALU, subtract;
  logic MI, RO, RI, CO, CE, J, OI, halted;
  logic [2:0] step_idx;
  wire  [12:0] ctl = {OI, J, CE, CO, RI, RO, MI, subtract, write_ALU, write_B, write_A, load_B, load_A};
  int total = 0;
  int bad = 0;

  assign bus = RO ? mem : 8'hzz;

  control_sequencer dut (
    .clk(clk), .rst(rst), .bus(bus), .run(run), .step(step),
    .carry_in(carry_in), .zero_in(zero_in),
    .load_A(load_A), .load_B(load_B), .write_A(write_A), .write_B(write_B),
    .write_ALU(write_ALU), .subtract(subtract), .MI(MI), .RO(RO), .RI(RI),
    .CO(CO), .CE(CE), .J(J), .OI(OI), .halted(halted), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic exec_silent(input logic [7:0] instr);
    mem = instr;
    run = 1'b1;
    repeat (5) to_next();
    run = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; step = 1'b0; mem = 8'h00; carry_in = 1'b0; zero_in = 1'b0;
    @(negedge clk);
    total++; if (ctl !== 13'h0) begin bad++; $display("FAIL reset_ctl got=%h want=0", ctl); end
    to_next();
    rst = 1'b0; run = 1'b0;
    @(negedge clk);
    total++; if (step_idx !== 3'd0) begin bad++; $display("FAIL reset_step got=%0d want=0", step_idx); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
    total++; if (ctl !== 13'h0) begin bad++; $display("FAIL reset_idle_ctl got=%h want=0", ctl); end
    to_next();
  endtask

  task automatic test_lda();
    logic [12:0] exp_c [5];
    exp_c = '{M_CO | M_MI, M_RO | M_CE, M_MI, M_RO | M_LA, 13'h0};
    mem = 8'h1E; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (ctl !== exp_c[i]) begin bad++; $display("FAIL lda_ctl T%0d got=%h want=%h", i, ctl, exp_c[i]); end
      total++; if (step_idx !== 3'(i)) begin bad++; $display("FAIL lda_step T%0d got=%0d want=%0d", i, step_idx, i); end
      if (i == 2) begin
        total++; if (bus !== 8'h0E) begin bad++; $display("FAIL lda_bus got=%h want=0e", bus); end
      end
      to_next();
    end
    run = 1'b0;
    @(negedge clk);
    total++; if (step_idx !== 3'd0) begin bad++; $display("FAIL lda_wrap got=%0d want=0", step_idx); end
    to_next();
  endtask

  task automatic test_add_flags();
    logic [12:0] exp_c [5];
    // JC with C=0 from reset: T2 must be empty.
    mem = 8'h75; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        total++; if (ctl !== 13'h0) begin bad++; $display("FAIL jc_c0_ctl got=%h want=0", ctl); end
      end
      to_next();
    end
    exp_c = '{M_CO | M_MI, M_RO | M_CE, M_MI, M_RO | M_LB, M_WALU | M_LA};
    mem = 8'h2A; carry_in = 1'b1; zero_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (ctl !== exp_c[i]) begin bad++; $display("FAIL add_ctl T%0d got=%h want=%h", i, ctl, exp_c[i]); end
      if (i == 2) begin
        total++; if (bus !== 8'h0A) begin bad++; $display("FAIL add_bus got=%h want=0a", bus); end
      end
      to_next();
    end
    carry_in = 1'b0;
    mem = 8'h75;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        total++; if (ctl !== M_J) begin bad++; $display("FAIL jc_c1_ctl got=%h want=%h", ctl, M_J); end
        total++; if (bus !== 8'h05) begin bad++; $display("FAIL jc_c1_bus got=%h want=05", bus); end
      end
      to_next();
    end
    mem = 8'h83;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        total++; if (ctl !== 13'h0) begin bad++; $display("FAIL jz_z0_ctl got=%h want=0", ctl); end
      end
      to_next();
    end
    run = 1'b0;
  endtask

  task automatic test_sub_flags();
    logic [12:0] exp_c [5];
    exp_c = '{M_CO | M_MI, M_RO | M_CE, M_MI, M_RO | M_LB, M_WALU | M_LA | M_SUB};
    mem = 8'h3F; carry_in = 1'b0; zero_in = 1'b1; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (ctl !== exp_c[i]) begin bad++; $display("FAIL sub_ctl T%0d got=%h want=%h", i, ctl, exp_c[i]); end
      to_next();
    end
    zero_in = 1'b0;
    mem = 8'h83;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        total++; if (ctl !== M_J) begin bad++; $display("FAIL jz_z1_ctl got=%h want=%h", ctl, M_J); end
        total++; if (bus !== 8'h03) begin bad++; $display("FAIL jz_z1_bus got=%h want=03", bus); end
      end
      to_next();
    end
    mem = 8'h75;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        total++; if (ctl !== 13'h0) begin bad++; $display("FAIL jc_after_sub_ctl got=%h want=0", ctl); end
      end
      to_next();
    end
    run = 1'b0;
  endtask

  task automatic test_single_step();
    logic        pulse [7];
    logic [12:0] exp_c [7];
    logic [2:0]  exp_s [7];
    pulse = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_c = '{13'h0, M_CO | M_MI, 13'h0, M_RO | M_CE, 13'h0, M_LA, 13'h0};
    exp_s = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3};
    run = 1'b0; mem = 8'h5C;
    for (int i = 0; i < 7; i++) begin
      step = pulse[i];
      if (i == 4) mem = 8'h99;
      @(negedge clk);
      total++; if (ctl !== exp_c[i]) begin bad++; $display("FAIL step_ctl c%0d got=%h want=%h", i, ctl, exp_c[i]); end
      total++; if (step_idx !== exp_s[i]) begin bad++; $display("FAIL step_idx c%0d got=%0d want=%0d", i, step_idx, exp_s[i]); end
      if (i == 5) begin
        total++; if (bus !== 8'h0C) begin bad++; $display("FAIL step_ldi_bus got=%h want=0c", bus); end
      end
      to_next();
    end
    run = 1'b1; step = 1'b1;
    to_next();
    run = 1'b0; step = 1'b0;
    @(negedge clk);
    total++; if (step_idx !== 3'd4) begin bad++; $display("FAIL run_and_step got=%0d want=4", step_idx); end
    run = 1'b1;
    to_next();
    run = 1'b0;
    @(negedge clk);
    total++; if (step_idx !== 3'd0) begin bad++; $display("FAIL step_wrap got=%0d want=0", step_idx); end
    to_next();
  endtask

  task automatic test_reset_mid();
    carry_in = 1'b1; zero_in = 1'b1;
    exec_silent(8'h2F);
    mem = 8'h2F; run = 1'b1;
    repeat (3) to_next();
    @(negedge clk);
    total++; if (step_idx !== 3'd3) begin bad++; $display("FAIL mid_pre_step got=%0d want=3", step_idx); end
    total++; if (ctl !== (M_RO | M_LB)) begin bad++; $display("FAIL mid_pre_ctl got=%h want=%h", ctl, M_RO | M_LB); end
    rst = 1'b1;
    #1;
    total++; if (ctl !== 13'h0) begin bad++; $display("FAIL mid_rst_ctl got=%h want=0", ctl); end
    to_next();
    rst = 1'b0; run = 1'b0; carry_in = 1'b0; zero_in = 1'b0;
    @(negedge clk);
    total++; if (step_idx !== 3'd0) begin bad++; $display("FAIL mid_post_step got=%0d want=0", step_idx); end
    total++; if (ctl !== 13'h0) begin bad++; $display("FAIL mid_post_ctl got=%h want=0", ctl); end
    to_next();
    run = 1'b1;
    mem = 8'h75;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        total++; if (ctl !== 13'h0) begin bad++; $display("FAIL mid_c_cleared got=%h want=0", ctl); end
      end
      to_next();
    end
    mem = 8'h83;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        total++; if (ctl !== 13'h0) begin bad++; $display("FAIL mid_z_cleared got=%h want=0", ctl); end
      end
      to_next();
    end
    run = 1'b0;
  endtask

  task automatic test_halt();
    logic [12:0] exp_c [3];
    exp_c = '{M_CO | M_MI, M_RO | M_CE, 13'h0};
    mem = 8'hF0; run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (ctl !== exp_c[i]) begin bad++; $display("FAIL hlt_ctl T%0d got=%h want=%h", i, ctl, exp_c[i]); end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL hlt_early T%0d got=%b want=0", i, halted); end
      to_next();
    end
    step = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL hlt_flag c%0d got=%b want=1", i, halted); end
      total++; if (ctl !== 13'h0) begin bad++; $display("FAIL hlt_quiet c%0d got=%h want=0", i, ctl); end
      total++; if (step_idx !== 3'd3) begin bad++; $display("FAIL hlt_step c%0d got=%0d want=3", i, step_idx); end
      to_next();
    end
    rst = 1'b1;
    to_next();
    rst = 1'b0; run = 1'b0; step = 1'b0;
    @(negedge clk);
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL hlt_rst_flag got=%b want=0", halted); end
    total++; if (step_idx !== 3'd0) begin bad++; $display("FAIL hlt_rst_step got=%0d want=0", step_idx); end
    to_next();
  endtask

  initial begin
    test_reset();
    test_lda();
    test_add_flags();
    test_sub_flags();
    test_single_step();
    test_reset_mid();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
